// File: rtl/image_uart_readback.sv
// Reads the processed image out of the output BRAM one pixel at a time and sends
// each byte to the host as an 8N1 UART frame (LSB first, idle-high line).
module image_uart_readback #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 14,
   parameter int NUM_PIXELS   = 16384
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [7:0]            mem_data,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done,
   output logic [2:0]            o_dbg_state
);

   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]         BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]         FETCH_LAST = BW'(1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t          r_state;
   logic [BW-1:0]   r_baud;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;

   assign o_dbg_state = r_state;

   // Outputs are registered: each transition also loads the value tx/busy/tx_done
   // must carry during the first cycle of the state being entered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         mem_addr <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               tx_done <= 1'b0;
               r_baud  <= '0;
               if (start) begin
                  mem_addr <= '0;
                  busy     <= 1'b1;
                  r_state  <= FETCH;
               end
            end
            FETCH: begin
               // BRAM data for the current address is stable by the second cycle
               if (r_baud == FETCH_LAST) begin
                  r_shift <= mem_data;
                  r_baud  <= '0;
                  tx      <= 1'b0;
                  r_state <= START;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            START: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  tx      <= r_shift[0];
                  r_state <= DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            DATA: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud  <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit == 3'd7) begin
                     tx      <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                     tx    <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            STOP: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud <= '0;
                  if (mem_addr == LAST_ADDR) begin
                     tx_done <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     mem_addr <= mem_addr + 1'b1;
                     r_state  <= FETCH;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            DONE: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               tx_done <= 1'b0;
               r_baud  <= '0;
               r_state <= IDLE;
            end
            default: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               tx_done <= 1'b0;
               r_baud  <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
